// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   Read-side controller for the 256x8 UART TX FIFO. It pops one byte at a
//   time and serialises it onto TX as an asynchronous frame: a start bit,
//   7 or 8 data bits sent LSB first, an optional parity bit, then the stop
//   bit(s). All logic runs on RCLOCK and is paced by the BAUD16 enable.
//
//   Optional feature macro: UART_TX_TWO_STOP_EN
//     defined   -> adds the STOP2 input; STOP2=1 stretches the stop bit to
//                  32 BAUD16 pulses.
//     undefined -> no STOP2 port; the stop bit is always 16 pulses.
//
//   Parameters
//     RD_LATENCY  cycles from the RDB-low cycle to valid DO (1..3)
//
//   Ports
//     RCLOCK      system clock, rising edge
//     RESET       asynchronous reset, active high
//     BAUD16      one-cycle baud x16 enable
//     EMPTY       FIFO empty flag
//     DO[7:0]     FIFO read data
//     RDB         FIFO read enable, active low
//     BIT8        1 = 8 data bits, 0 = 7 data bits
//     PARITY_EN   1 = append a parity bit
//     ODD_N_EVEN  1 = odd parity, 0 = even parity
//     STOP2       (macro only) 1 = double-length stop bit
//     TX          serial output, idles high
//     TX_BUSY     high from the FIFO read until the last stop bit ends
module uart_tx_fifo_reader #(
    parameter int RD_LATENCY = 2
) (
    input  logic       RCLOCK,
    input  logic       RESET,
    input  logic       BAUD16,
    input  logic       EMPTY,
    input  logic [7:0] DO,
    output logic       RDB,
    input  logic       BIT8,
    input  logic       PARITY_EN,
    input  logic       ODD_N_EVEN,
`ifdef UART_TX_TWO_STOP_EN
    input  logic       STOP2,
`endif
    output logic       TX,
    output logic       TX_BUSY
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAITD, LOAD, START, DATA, PARITY, STOP
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t     state_q;
    logic [1:0] wait_q;
    logic [4:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       bit8_q;
    logic       par_en_q;
    logic       par_q;
    logic       stop2_q;
    logic       tx_q;
    logic       rdb_q;
    logic       busy_q;

    logic       par_d;
    logic       stop2_d;
    logic       bit_end;
    logic [2:0] last_bit;
    logic [4:0] stop_last;

`ifdef UART_TX_TWO_STOP_EN
    assign stop2_d = STOP2;
`else
    assign stop2_d = 1'b0;
`endif

    // Parity is computed from the byte as it is captured; DO[7] only counts
    // in 8-bit mode.
    assign par_d     = (^DO[6:0]) ^ (BIT8 & DO[7]) ^ ODD_N_EVEN;
    assign bit_end   = BAUD16 && (tick_q == 5'd15);
    assign last_bit  = bit8_q ? 3'd7 : 3'd6;
    assign stop_last = stop2_q ? 5'd31 : 5'd15;

    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            bit8_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            rdb_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            // RDB is a one-cycle strobe; only the transitions into FETCH
            // pull it low.
            rdb_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!EMPTY) begin
                        state_q <= FETCH;
                        rdb_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    wait_q  <= '0;
                    state_q <= WAITD;
                end
                WAITD: begin
                    // The read is committed; EMPTY is not looked at here.
                    if (wait_q == WAIT_LAST) begin
                        shift_q  <= {DO[7] & BIT8, DO[6:0]};
                        bit8_q   <= BIT8;
                        par_en_q <= PARITY_EN;
                        par_q    <= par_d;
                        stop2_q  <= stop2_d;
                        state_q  <= LOAD;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                LOAD: begin
                    if (BAUD16) begin
                        tx_q    <= 1'b0;
                        tick_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else if (BAUD16) begin
                        tick_q <= tick_q + 5'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_q <= '0;
                        if (bit_q == last_bit) begin
                            if (par_en_q) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else if (BAUD16) begin
                        tick_q <= tick_q + 5'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else if (BAUD16) begin
                        tick_q <= tick_q + 5'd1;
                    end
                end
                STOP: begin
                    if (BAUD16) begin
                        if (tick_q == stop_last) begin
                            tick_q <= '0;
                            // Chain straight into the next read when data is
                            // waiting; TX_BUSY then never drops between frames.
                            if (!EMPTY) begin
                                state_q <= FETCH;
                                rdb_q   <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TX      = tx_q;
    assign RDB     = rdb_q;
    assign TX_BUSY = busy_q;

endmodule
